instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Sequencer for the instruction transmit block. It drives the transmitter's sync request, frames the returned stream on START/STOP marker words, and buffers payload instructions in a small FIFO. Payload words are delivered downstream over a valid/ready interface. Flow control and the transmitter's one-word in-flight latency are handled here, so no word is lost.

Parameters:
IWIDTH, 32, instruction width; must match the transmitter.
FIFO_DEPTH, 8, payload buffer entries; power of two, at least 4.
START_WORD, 32'hAAAA_AAAA, frame-start marker; consumed, never buffered.
STOP_WORD, 32'h5555_5555, frame-end marker; consumed, never buffered.
MAX_LEN, 34, maximum payload words per frame before abort.
TIMEOUT, 16, watchdog cycles; used only with FETCH_TIMEOUT_EN.

Ports:
t_clk  in  1  clock
t_rst  in  1  reset, asynchronous, active-low
c_i_en  in  1  level; high starts or continues a fetch; low aborts or clears
c_o_syn  out  1  registered sync request to the transmitter
c_i_instr  in  IWIDTH  word from the transmitter
c_i_ack  in  1  c_i_instr is valid this cycle
c_o_instr  out  IWIDTH  FIFO head payload word
c_o_valid  out  1  FIFO not empty
c_i_ready  in  1  downstream accepts the head word when valid and ready are both high
c_o_busy  out  1  state is not IDLE, DONE or ERR
c_o_done  out  1  one-cycle pulse when the frame completes
c_o_err  out  1  sticky error flag
c_o_count  out  8  payload words pushed in the current frame

Behaviour:
- Reset values (async, on t_rst low): state IDLE; c_o_syn=0; c_o_valid=0; c_o_instr=0; c_o_busy=0; c_o_done=0; c_o_err=0; c_o_count=0; FIFO pointers 0.
- Transmitter contract:
  - A word returns with ack one cycle after an edge at which syn is high and was also high at the previous edge.
  - Each further high cycle of syn yields one more word.
  - After syn falls, exactly one word can still arrive.
- Throttle: c_o_syn is high only in SYNC or RUN and when free entries are at least 3; otherwise it is driven low. FIFO overflow is therefore impossible in normal operation.
- IDLE: when c_i_en=1, go to SYNC and clear c_o_count.
- SYNC: every acked word that is not START_WORD is discarded. START_WORD moves the block to RUN.
- RUN: acked words other than STOP_WORD are pushed to the FIFO and c_o_count is incremented.
  - STOP_WORD moves to DRAIN and drops syn the following cycle.
  - If a push would make the count exceed MAX_LEN, go to ERR and do not push the word.
- DRAIN: syn is low and any in-flight ack is discarded. When the FIFO is empty, pulse c_o_done for 1 cycle and go to DONE.
- DONE: hold until c_i_en=0, then go to IDLE. c_o_count keeps its value until the next start.
- ERR: c_o_err=1, syn=0, the FIFO is flushed (c_o_valid=0). Leave to IDLE only when c_i_en=0.
- Abort: c_i_en=0 in SYNC, RUN or DRAIN goes to IDLE next cycle, with syn low and the FIFO flushed. There is no done pulse and no error.
- Push and pop in the same cycle are allowed at any occupancy, including full, and leave occupancy unchanged.
- c_o_instr/c_o_valid are driven combinationally from the FIFO head; first-word fall-through, zero-cycle output latency.
- An ack that arrives while the FIFO is full is dropped and forces ERR (defensive check).

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: a counter clears on every ack and counts cycles in which c_o_syn=1 in SYNC or RUN. Reaching TIMEOUT goes to ERR.
- Undefined: no counter; the block waits indefinitely and the TIMEOUT parameter is ignored.

Test Plan:
- Stream 0x1, START, 0x10..0x13, STOP with c_i_ready=1 -> output 0x10,0x11,0x12,0x13 in order, c_o_count=4, one c_o_done pulse, c_o_err=0.
- Same frame with c_i_ready=0 until 6 payload words are held, FIFO_DEPTH=8 -> syn low while free entries <3, no word lost, FIFO never exceeds 8.
- START followed by 35 payload words and no STOP -> ERR at word 35, c_o_err=1, c_o_valid=0; drop c_i_en -> IDLE, c_o_err=0 only after the next start.
- c_i_en dropped mid-RUN after 2 words -> IDLE next cycle, syn=0, FIFO flushed, no done pulse.
- Reset asserted mid-RUN with 3 words buffered -> all outputs at reset values immediately; after release with c_i_en=1, restart in SYNC.
- With FETCH_TIMEOUT_EN and TIMEOUT=16, ack held low while syn is high -> c_o_err=1 at cycle 16; without the macro -> still busy at cycle 100.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: drives the transmitter sync request, frames START/STOP and buffers payload.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_ctrl #(
   parameter int                IWIDTH     = 32,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [IWIDTH-1:0] START_WORD = 32'hAAAA_AAAA,
   parameter logic [IWIDTH-1:0] STOP_WORD  = 32'h5555_5555,
   parameter int                MAX_LEN    = 34,
   parameter int                TIMEOUT    = 16
) (
   input  logic              t_clk,
   input  logic              t_rst,
   input  logic              c_i_en,
   output logic              c_o_syn,
   input  logic [IWIDTH-1:0] c_i_instr,
   input  logic              c_i_ack,
   output logic [IWIDTH-1:0] c_o_instr,
   output logic              c_o_valid,
   input  logic              c_i_ready,
   output logic              c_o_busy,
   output logic              c_o_done,
   output logic              c_o_err,
   output logic [7:0]        c_o_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, DONE, ERR} state_t;

   state_t            state, state_next;
   logic [IWIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       occ, occ_next, free_next;
   logic              push, pop, flush, full, empty, overflow;
   logic              cnt_clr, cnt_inc, done_next, syn_next, fetching, timeout_hit;

   assign full      = (occ == (AW+1)'(FIFO_DEPTH));
   assign empty     = (occ == '0);
   assign c_o_valid = !empty;
   assign c_o_instr = c_o_valid ? mem[rd_ptr] : '0;
   assign pop       = c_o_valid && c_i_ready;
   assign overflow  = c_i_ack && full && !pop;
   assign fetching  = (state == SYNC) || (state == RUN);
   assign c_o_busy  = fetching || (state == DRAIN);

`ifdef FETCH_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wd_count;

   assign timeout_hit = fetching && c_o_syn && !c_i_ack && (wd_count == WW'(TIMEOUT - 1));

   // Watchdog counts requested-but-unanswered cycles; any ack restarts it.
   always_ff @(posedge t_clk or negedge t_rst) begin
      if (!t_rst)
         wd_count <= '0;
      else if (c_i_ack || !fetching)
         wd_count <= '0;
      else if (c_o_syn)
         wd_count <= wd_count + WW'(1);
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_next = state;
      push       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (c_i_en) begin
               state_next = SYNC;
               cnt_clr    = 1'b1;
            end
         end
         SYNC: begin
            if (!c_i_en)
               state_next = IDLE;
            else if (timeout_hit)
               state_next = ERR;
            else if (c_i_ack && c_i_instr == START_WORD)
               state_next = RUN;
         end
         RUN: begin
            if (!c_i_en)
               state_next = IDLE;
            else if (timeout_hit || overflow)
               state_next = ERR;
            else if (c_i_ack) begin
               if (c_i_instr == STOP_WORD)
                  state_next = DRAIN;
               else if (c_o_count == 8'(MAX_LEN))
                  state_next = ERR;
               else begin
                  push    = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!c_i_en)
               state_next = IDLE;
            else if (overflow)
               state_next = ERR;
            else if (empty) begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end
         DONE, ERR: begin
            if (!c_i_en)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Entering IDLE or ERR always empties the buffer; it is already empty coming from DONE.
      flush = (state_next == IDLE) || (state_next == ERR);

      occ_next = occ;
      if (flush)
         occ_next = '0;
      else if (push && !pop)
         occ_next = occ + (AW+1)'(1);
      else if (pop && !push)
         occ_next = occ - (AW+1)'(1);

      // Three free entries cover the word being requested plus the one already in flight.
      free_next = (AW+1)'(FIFO_DEPTH) - occ_next;
      syn_next  = ((state_next == SYNC) || (state_next == RUN)) && (free_next >= (AW+1)'(3));
   end

   always_ff @(posedge t_clk or negedge t_rst) begin
      if (!t_rst) begin
         state     <= IDLE;
         c_o_syn   <= 1'b0;
         c_o_done  <= 1'b0;
         c_o_err   <= 1'b0;
         c_o_count <= '0;
      end else begin
         state    <= state_next;
         c_o_syn  <= syn_next;
         c_o_done <= done_next;
         if (state_next == ERR)
            c_o_err <= 1'b1;
         else if (cnt_clr)
            c_o_err <= 1'b0;
         if (cnt_clr)
            c_o_count <= '0;
         else if (cnt_inc)
            c_o_count <= c_o_count + 8'd1;
      end
   end

   always_ff @(posedge t_clk or negedge t_rst) begin
      if (!t_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         occ <= occ_next;
      end
   end

   always_ff @(posedge t_clk) begin
      if (push)
         mem[wr_ptr] <= c_i_instr;
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: transmitter model, scoreboard of payload words, frame table and random frames.
module tb_instr_fetch_ctrl;

   localparam int          DEPTH   = 8;
   localparam int          MAXLEN  = 34;
   localparam logic [31:0] START_W = 32'hAAAA_AAAA;
   localparam logic [31:0] STOP_W  = 32'h5555_5555;

   logic        t_clk = 1'b0;
   logic        t_rst = 1'b0;
   logic        c_i_en = 1'b0;
   logic        c_o_syn;
   logic [31:0] c_i_instr = '0;
   logic        c_i_ack = 1'b0;
   logic [31:0] c_o_instr;
   logic        c_o_valid;
   logic        c_i_ready = 1'b0;
   logic        c_o_busy, c_o_done, c_o_err;
   logic [7:0]  c_o_count;

   instr_fetch_ctrl dut (
      .t_clk(t_clk), .t_rst(t_rst), .c_i_en(c_i_en), .c_o_syn(c_o_syn),
      .c_i_instr(c_i_instr), .c_i_ack(c_i_ack), .c_o_instr(c_o_instr),
      .c_o_valid(c_o_valid), .c_i_ready(c_i_ready), .c_o_busy(c_o_busy),
      .c_o_done(c_o_done), .c_o_err(c_o_err), .c_o_count(c_o_count)
   );

   always #5 t_clk = ~t_clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] stream[$];
   logic [31:0] expq[$];
   logic [31:0] got[$];
   int          ack_idx, pay_lo, pay_hi, payload_acked, done_pulses, max_held;
   int          ready_mode = 0;
   bit          tx_mute = 1'b0;
   bit          syn_d1 = 1'b0, syn_d2 = 1'b0;

   // Transmitter and downstream model: a word answers each sync cycle that follows another sync cycle.
   always @(negedge t_clk) begin
      logic        ack;
      logic [31:0] word;
      int          held;
      case (ready_mode)
         0:       c_i_ready = 1'b1;
         1:       c_i_ready = ($urandom_range(0, 3) != 0);
         default: c_i_ready = 1'b0;
      endcase
      ack    = syn_d1 && syn_d2 && !tx_mute;
      syn_d2 = syn_d1;
      syn_d1 = c_o_syn;
      word   = 32'h0BAD_0000 | 32'($urandom_range(0, 65535));
      if (ack) begin
         if (stream.size() > 0)
            word = stream.pop_front();
         if (ack_idx >= pay_lo && ack_idx < pay_hi)
            payload_acked++;
         ack_idx++;
      end
      c_i_ack   = ack;
      c_i_instr = word;
      if (c_o_valid && c_i_ready)
         got.push_back(c_o_instr);
      if (c_o_done)
         done_pulses++;
      held = payload_acked - got.size();
      if (held > max_held)
         max_held = held;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge t_clk);
         #1;
      end
   endtask

   task automatic load_frame(input int garbage, input int len, input logic [31:0] base, input bit stop);
      logic [31:0] w;
      stream.delete();
      expq.delete();
      got.delete();
      ack_idx       = 0;
      payload_acked = 0;
      done_pulses   = 0;
      max_held      = 0;
      for (int i = 0; i < garbage; i++)
         stream.push_back(32'h0000_0001 + 32'(i));
      stream.push_back(START_W);
      pay_lo = garbage + 1;
      pay_hi = pay_lo + len;
      for (int i = 0; i < len; i++) begin
         w = (base != 0) ? base + 32'(i) : $urandom;
         if (w == STOP_W)
            w = w ^ 32'h1;
         stream.push_back(w);
         expq.push_back(w);
      end
      if (stop)
         stream.push_back(STOP_W);
   endtask

   task automatic wait_held(input int target);
      for (int c = 0; c < 300; c++) begin
         if (payload_acked - int'(got.size()) >= target)
            return;
         tick(1);
      end
      check_output("wait_held_bound", 32'd0, 32'd1);
   endtask

   // Runs one frame to DONE or ERR and scores it against the expected outcome.
   task automatic apply_stimulus(input int garbage, input int len, input logic [31:0] base, input bit stop,
                                 input int rmode, input bit exp_done, input bit exp_err, input int exp_count);
      bit finished = 0;
      load_frame(garbage, len, base, stop);
      ready_mode = rmode;
      c_i_en     = 1'b1;
      tick(1);
      check_output("start_busy", 32'(c_o_busy), 32'd1);
      check_output("start_err_clear", 32'(c_o_err), 32'd0);
      check_output("start_count_clear", 32'(c_o_count), 32'd0);
      for (int c = 0; c < 3000; c++) begin
         tick(1);
         if (done_pulses > 0 || c_o_err) begin
            finished = 1;
            break;
         end
      end
      check_output("frame_finished", 32'(finished), 32'd1);
      check_output("frame_done", 32'(done_pulses > 0), 32'(exp_done));
      check_output("frame_err", 32'(c_o_err), 32'(exp_err));
      check_output("frame_count", 32'(c_o_count), 32'(exp_count));
      check_output("frame_busy_end", 32'(c_o_busy), 32'd0);
      if (exp_err) begin
         check_output("err_valid_low", 32'(c_o_valid), 32'd0);
         check_output("err_delivered_le_max", 32'(got.size() <= MAXLEN), 32'd1);
      end else begin
         check_output("delivered_len", 32'(got.size()), 32'(expq.size()));
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         check_output($sformatf("word_%0d", i), got[i], expq[i]);
      c_i_en = 1'b0;
      tick(3);
      check_output("done_pulse_count", 32'(done_pulses), exp_done ? 32'd1 : 32'd0);
      check_output("idle_err_sticky", 32'(c_o_err), 32'(exp_err));
      check_output("idle_busy", 32'(c_o_busy), 32'd0);
   endtask

   typedef struct {
      int          garbage;
      int          len;
      logic [31:0] base;
      bit          stop;
      int          rmode;
      bit          exp_done;
      bit          exp_err;
      int          exp_count;
   } vec_t;

   initial begin
      vec_t vecs[6];
      vecs[0] = '{1,  4, 32'h10, 1'b1, 0, 1'b1, 1'b0,  4};
      vecs[1] = '{0,  0, 32'h0,  1'b1, 0, 1'b1, 1'b0,  0};
      vecs[2] = '{2, 34, 32'h0,  1'b1, 1, 1'b1, 1'b0, 34};
      vecs[3] = '{0, 35, 32'h0,  1'b0, 0, 1'b0, 1'b1, 34};
      vecs[4] = '{3,  9, 32'h0,  1'b1, 1, 1'b1, 1'b0,  9};
      vecs[5] = '{1, 40, 32'h0,  1'b1, 1, 1'b0, 1'b1, 34};

      tick(2);
      check_output("rst_syn", 32'(c_o_syn), 32'd0);
      check_output("rst_valid", 32'(c_o_valid), 32'd0);
      check_output("rst_instr", c_o_instr, 32'd0);
      check_output("rst_busy", 32'(c_o_busy), 32'd0);
      check_output("rst_done", 32'(c_o_done), 32'd0);
      check_output("rst_err", 32'(c_o_err), 32'd0);
      check_output("rst_count", 32'(c_o_count), 32'd0);
      t_rst = 1'b1;
      tick(2);

      for (int v = 0; v < 6; v++)
         apply_stimulus(vecs[v].garbage, vecs[v].len, vecs[v].base, vecs[v].stop, vecs[v].rmode,
                        vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_count);

      // Throttle: downstream stalls, sync must stop before the buffer can overflow.
      load_frame(1, 12, 32'h0, 1'b1);
      ready_mode = 2;
      c_i_en     = 1'b1;
      wait_held(6);
      tick(10);
      check_output("throttle_syn_low", 32'(c_o_syn), 32'd0);
      check_output("throttle_valid", 32'(c_o_valid), 32'd1);
      check_output("throttle_le_depth", 32'(max_held <= DEPTH), 32'd1);
      ready_mode = 0;
      for (int c = 0; c < 300 && done_pulses == 0; c++)
         tick(1);
      check_output("throttle_done", 32'(done_pulses), 32'd1);
      check_output("throttle_count", 32'(c_o_count), 32'd12);
      check_output("throttle_len", 32'(got.size()), 32'd12);
      for (int i = 0; i < got.size() && i < 12; i++)
         check_output($sformatf("throttle_word_%0d", i), got[i], expq[i]);
      c_i_en = 1'b0;
      tick(3);

      // Abort mid-frame with words buffered.
      load_frame(0, 10, 32'h0, 1'b1);
      ready_mode = 2;
      c_i_en     = 1'b1;
      wait_held(2);
      tick(1);
      check_output("abort_pre_valid", 32'(c_o_valid), 32'd1);
      c_i_en = 1'b0;
      tick(1);
      check_output("abort_busy", 32'(c_o_busy), 32'd0);
      check_output("abort_syn", 32'(c_o_syn), 32'd0);
      check_output("abort_valid", 32'(c_o_valid), 32'd0);
      check_output("abort_err", 32'(c_o_err), 32'd0);
      tick(3);
      check_output("abort_no_done", 32'(done_pulses), 32'd0);

      // Asynchronous reset mid-frame, then restart with enable held high.
      load_frame(0, 10, 32'h0, 1'b1);
      ready_mode = 2;
      c_i_en     = 1'b1;
      wait_held(3);
      tick(1);
      check_output("rst_mid_pre_valid", 32'(c_o_valid), 32'd1);
      t_rst   = 1'b0;
      tx_mute = 1'b1;
      #1;
      check_output("rst_mid_syn", 32'(c_o_syn), 32'd0);
      check_output("rst_mid_valid", 32'(c_o_valid), 32'd0);
      check_output("rst_mid_instr", c_o_instr, 32'd0);
      check_output("rst_mid_busy", 32'(c_o_busy), 32'd0);
      check_output("rst_mid_count", 32'(c_o_count), 32'd0);
      tick(1);
      t_rst = 1'b1;
      tick(1);
      check_output("restart_busy", 32'(c_o_busy), 32'd1);
      check_output("restart_syn", 32'(c_o_syn), 32'd1);
      check_output("restart_count", 32'(c_o_count), 32'd0);
      c_i_en = 1'b0;
      tick(3);

      // Transmitter silent while sync is requested.
      begin
         int err_at = -1;
         c_i_en = 1'b1;
         for (int c = 1; c <= 100 && err_at < 0; c++) begin
            tick(1);
            if (c_o_err)
               err_at = c;
         end
`ifdef FETCH_TIMEOUT_EN
         check_output("timeout_err", 32'(c_o_err), 32'd1);
         check_output("timeout_window", 32'(err_at >= 12 && err_at <= 22), 32'd1);
`else
         check_output("no_timeout_busy", 32'(c_o_busy), 32'd1);
         check_output("no_timeout_err", 32'(c_o_err), 32'd0);
         check_output("no_timeout_syn", 32'(c_o_syn), 32'd1);
`endif
         c_i_en = 1'b0;
         tick(3);
         tx_mute = 1'b0;
      end

      // Random frames scored against the framing rules.
      for (int f = 0; f < 10; f++) begin
         int len;
         bit too_long;
         len      = $urandom_range(0, 40);
         too_long = (len > MAXLEN);
         apply_stimulus($urandom_range(0, 4), len, 32'h0, 1'b1, 1, !too_long, too_long,
                        too_long ? MAXLEN : len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
